line_mem_responder: RTL and testbench

- Memory-side responder for the 128-bit line interface driven by the L1 instruction/data caches.
- Accepts one line read or line write at a time, applies a fixed access latency, and returns a single-cycle mem_ready pulse.
- Read data stays on mem_rdata with that pulse.
- Backed by an internal line array; serves as the L2/main-memory stand-in below the L1 caches in the pipelined RISC-V system.

---
 rtl/line_mem_responder.sv | 106 ++++++++++
 tb/tb_line_mem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// Memory-side line responder for the L1 caches: one read or write at a time,
// fixed access latency, single-cycle mem_ready pulse, registered read data.
module line_mem_responder #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int IDX_W   = 8,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              err
);

  localparam int          DEPTH  = 2 ** IDX_W;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               wr_q, wr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  rdata_q;
  logic               commit;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  // Upper address bits alias onto the same lines by design.
  logic unused_addr;
  assign unused_addr = ^mem_addr[ADDR_W-1:IDX_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          idx_d   = mem_addr[IDX_W-1:0];
          wr_d    = mem_write;
          wdata_d = mem_wdata;
          cnt_d   = LAT_M1;
          if (mem_read && mem_write) err_d = 1'b1;
          state_d = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The access takes effect on the edge entering RESP; the _d values hold the
  // request whether it was latched earlier or is being accepted this edge.
  assign commit = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit) begin
      if (wr_d) mem_q[idx_d] <= wdata_d;
      else      rdata_q      <= mem_q[idx_d];
    end
  end

  assign mem_ready = (state_q == RESP);
  assign mem_rdata = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed and randomized checks of line_mem_responder against a line-array
// reference model kept in the bench.
module tb_line_mem_responder;

  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int IDX_W   = 8;
  localparam int LATENCY = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              err;

  line_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: the line array, last read line and sticky error.
  logic [DATA_W-1:0] exp_mem [2**IDX_W];
  logic [DATA_W-1:0] exp_rdata;
  logic              exp_err;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2**IDX_W; i++) exp_mem[i] = '0;
    exp_rdata = '0;
    exp_err   = 1'b0;
  endtask

  // One cache-style transaction: request held through the ready cycle,
  // dropped the cycle after, inputs scrambled while the access is in flight.
  task automatic do_op(input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data);
    int lat;
    bit got;
    logic [DATA_W-1:0] prev_rdata;
    @(negedge clk);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = data;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (mem_ready) got = 1;
      else begin
        chk("ready_low_busy", {127'b0, mem_ready}, '0);
        mem_addr  = addr + 28'd1;
        mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    chk("ready_seen", {127'b0, got}, 128'd1);
    chk("latency", 128'(lat), 128'(LATENCY));
    if (wr) exp_mem[addr[IDX_W-1:0]] = data;
    else    exp_rdata = exp_mem[addr[IDX_W-1:0]];
    if (rd && wr) exp_err = 1'b1;
    chk(wr ? "rdata_after_write" : "rdata_read", mem_rdata, exp_rdata);
    chk("err", {127'b0, err}, {127'b0, exp_err});
    prev_rdata = mem_rdata;
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < LATENCY + 1; i++) begin
      chk("ready_low_after", {127'b0, mem_ready}, '0);
      chk("rdata_hold", mem_rdata, prev_rdata);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit is_wr;
    model_reset();
    #1;
    chk("rst_ready", {127'b0, mem_ready}, '0);
    chk("rst_rdata", mem_rdata, '0);
    chk("rst_err", {127'b0, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read of reset contents, then write/read-back.
    do_op(1'b1, 1'b0, 28'h0000005, '0);
    do_op(1'b0, 1'b1, 28'h0000005, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    do_op(1'b1, 1'b0, 28'h0000005, '0);
    chk("raw_0x5", mem_rdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);

    // Address change during BUSY must not redirect the read.
    do_op(1'b0, 1'b1, 28'h0000010, 128'h1010_1010);
    do_op(1'b0, 1'b1, 28'h0000011, 128'h1111_1111);
    do_op(1'b1, 1'b0, 28'h0000010, '0);
    chk("busy_addr_ignored", mem_rdata, 128'h1010_1010);

    // Aliasing modulo 2^IDX_W.
    do_op(1'b0, 1'b1, 28'h0000105, 128'hA11A5);
    do_op(1'b1, 1'b0, 28'h0000005, '0);
    chk("alias_0x105", mem_rdata, 128'hA11A5);

    // Randomized mix over a small index window with random upper bits.
    for (int n = 0; n < 30; n++) begin
      a = {20'($urandom), 8'($urandom_range(0, 15))};
      d = {$urandom, $urandom, $urandom, $urandom};
      is_wr = ($urandom_range(0, 1) == 1);
      do_op(~is_wr, is_wr, a, d);
    end

    // Simultaneous read+write: treated as a write, err sticky.
    do_op(1'b1, 1'b1, 28'h3, 128'h1);
    chk("err_set", {127'b0, err}, 128'd1);
    do_op(1'b1, 1'b0, 28'h3, '0);
    chk("both_is_write", mem_rdata, 128'h1);
    chk("err_sticky", {127'b0, err}, 128'd1);

    // Reset during BUSY drops the write.
    @(negedge clk);
    mem_write = 1'b1;
    mem_addr  = 28'h7;
    mem_wdata = 128'hBAD0_BAD0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy_ready", {127'b0, mem_ready}, '0);
    chk("rst_busy_err", {127'b0, err}, '0);
    chk("rst_busy_rdata", mem_rdata, '0);
    mem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b1, 1'b0, 28'h7, '0);
    chk("dropped_write_0x7", mem_rdata, '0);
    do_op(1'b1, 1'b0, 28'h3, '0);
    chk("rst_cleared_0x3", mem_rdata, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
